// File: rtl/placar_basquete_param.sv
// Parameterised basketball scoreboard: saturating per-team scores with sticky
// overflow flags, plus a shot clock with run/pause/expired states and a buzzer.
module placar_basquete_param #(
    parameter int NUM_TEAMS  = 2,
    parameter int SCORE_W    = 8,
    parameter int SCORE_MAX  = 199,
    parameter int SHOT_LONG  = 24,
    parameter int SHOT_SHORT = 14,
    parameter int BUZZ_TICKS = 3,
    localparam int TW = (NUM_TEAMS > 2) ? $clog2(NUM_TEAMS) : 1
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         tick_1hz,
    input  logic                         pts_valid,
    input  logic [1:0]                   pts,
    input  logic                         pts_neg,
    input  logic [TW-1:0]                team_sel,
    input  logic                         clr_score,
    input  logic                         shot_reset,
    input  logic                         shot_short,
    input  logic                         shot_pause,
    output logic [NUM_TEAMS*SCORE_W-1:0] scores,
    output logic [NUM_TEAMS-1:0]         ovf,
    output logic                         err,
    output logic [4:0]                   shot_count,
    output logic                         buzzer
);

    localparam int BW = (BUZZ_TICKS < 2) ? 1 : $clog2(BUZZ_TICKS);
    localparam logic [4:0] LONG5  = 5'(SHOT_LONG);
    localparam logic [4:0] SHORT5 = 5'(SHOT_SHORT);

    typedef enum logic [1:0] {RUN, PAUSED, EXPIRED} shot_state_t;

    logic [SCORE_W-1:0] score_q [NUM_TEAMS];
    logic [SCORE_W-1:0] cur, nxt;
    logic [SCORE_W+1:0] sum;
    logic               wr, sat, err_d;
    shot_state_t        state;
    logic [BW-1:0]      buzz_cnt;

    for (genvar g = 0; g < NUM_TEAMS; g++) begin : g_flat
        assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    // Widened sum keeps the saturation compare free of wrap-around.
    always_comb begin
        cur = '0;
        for (int unsigned i = 0; i < NUM_TEAMS; i++)
            if (team_sel == TW'(i)) cur = score_q[i];
        sum   = (SCORE_W+2)'(cur) + (SCORE_W+2)'(pts);
        nxt   = cur;
        wr    = 1'b0;
        sat   = 1'b0;
        err_d = 1'b0;
        if (pts_valid && pts != 2'd0) begin
            if (int'(team_sel) >= NUM_TEAMS) begin
                err_d = 1'b1;
            end else if (pts_neg) begin
                if ((SCORE_W+2)'(pts) > (SCORE_W+2)'(cur)) begin
                    err_d = 1'b1;
                end else begin
                    wr  = 1'b1;
                    nxt = cur - SCORE_W'(pts);
                end
            end else if (sum > (SCORE_W+2)'(SCORE_MAX)) begin
                wr  = 1'b1;
                sat = 1'b1;
                nxt = SCORE_W'(SCORE_MAX);
            end else begin
                wr  = 1'b1;
                nxt = sum[SCORE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr || clr_score) begin
            for (int unsigned i = 0; i < NUM_TEAMS; i++) score_q[i] <= '0;
            ovf <= '0;
            err <= 1'b0;
        end else begin
            err <= err_d;
            for (int unsigned i = 0; i < NUM_TEAMS; i++) begin
                if (wr && team_sel == TW'(i)) begin
                    score_q[i] <= nxt;
                    if (sat) ovf[i] <= 1'b1;
                end
            end
        end
    end

    // buzz_cnt counts ticks already heard while the alarm sounds.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= PAUSED;
            shot_count <= LONG5;
            buzzer     <= 1'b0;
            buzz_cnt   <= '0;
        end else if (shot_reset) begin
            shot_count <= shot_short ? SHORT5 : LONG5;
            state      <= shot_pause ? PAUSED : RUN;
            buzzer     <= 1'b0;
            buzz_cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (shot_pause) begin
                        state <= PAUSED;
                    end else if (tick_1hz) begin
                        if (shot_count <= 5'd1) begin
                            shot_count <= '0;
                            state      <= EXPIRED;
                            buzzer     <= 1'b1;
                            buzz_cnt   <= '0;
                        end else begin
                            shot_count <= shot_count - 5'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (!shot_pause) state <= RUN;
                end
                EXPIRED: begin
                    shot_count <= '0;
                    if (buzzer && tick_1hz) begin
                        if (buzz_cnt == BW'(BUZZ_TICKS - 1)) buzzer <= 1'b0;
                        else buzz_cnt <= buzz_cnt + 1'b1;
                    end
                end
                default: state <= PAUSED;
            endcase
        end
    end

endmodule

// File: doc/placar_basquete_param.md
PLACAR_BASQUETE_PARAM -- requirements
Module: placar_basquete_param

Interface
REQ-001 Parameter NUM_TEAMS, default 2, number of independent team score registers (2..8).
REQ-002 Parameter SCORE_W, default 8, width of each team score.
REQ-003 Parameter SCORE_MAX, default 199, saturation ceiling of each score (at most 2^SCORE_W-1).
REQ-004 Parameter SHOT_LONG, default 24, long shot-clock preset in seconds (at most 31).
REQ-005 Parameter SHOT_SHORT, default 14, short shot-clock preset in seconds (at most 31).
REQ-006 Parameter BUZZ_TICKS, default 3, buzzer duration in tick_1hz periods (at least 1).
REQ-007 Port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-008 Port clr  input  1  synchronous, active-high reset.
REQ-009 Port tick_1hz  input  1  one-cycle enable strobe, once per second.
REQ-010 Port pts_valid  input  1  one-cycle strobe requesting a score operation.
REQ-011 Port pts  input  2  point value, 0..3.
REQ-012 Port pts_neg  input  1  1 = subtract, 0 = add.
REQ-013 Port team_sel  input  max(1,$clog2(NUM_TEAMS))  target team index.
REQ-014 Port clr_score  input  1  zeroes all scores and overflow flags.
REQ-015 Port shot_reset  input  1  reloads the shot clock.
REQ-016 Port shot_short  input  1  selects SHOT_SHORT (1) or SHOT_LONG (0) on reload.
REQ-017 Port shot_pause  input  1  level; freezes the shot clock while high.
REQ-018 Port scores  output  NUM_TEAMS*SCORE_W  flattened scores, team 0 in the LSBs.
REQ-019 Port ovf  output  NUM_TEAMS  sticky per-team saturation flags.
REQ-020 Port err  output  1  one-cycle pulse on a rejected score operation.
REQ-021 Port shot_count  output  5  remaining shot-clock seconds.
REQ-022 Port buzzer  output  1  high while the expiry alarm sounds.

Function
REQ-023 Score update latency SHALL be one clk cycle: scores reflects pts_valid on the following cycle.
REQ-024 Add with score+pts <= SCORE_MAX SHALL store score+pts, computed at SCORE_W+2 bits to avoid wrap.
REQ-025 Add with score+pts > SCORE_MAX SHALL store SCORE_MAX and set ovf[team_sel].
REQ-026 Subtract with pts <= score SHALL store score-pts.
REQ-027 Subtract with pts > score SHALL leave the score unchanged and pulse err.
REQ-028 pts_valid with pts=0 SHALL change no state and SHALL NOT pulse err.
REQ-029 pts_valid with team_sel >= NUM_TEAMS SHALL change no score and SHALL pulse err.
REQ-030 ovf[i] SHALL remain set until clr or clr_score; subtraction SHALL NOT clear it.
REQ-031 clr_score SHALL take priority over a same-cycle pts_valid, which is discarded without err.
REQ-032 The shot-clock FSM SHALL have states RUN, PAUSED and EXPIRED.
REQ-033 shot_reset SHALL load the preset selected by shot_short and enter RUN, or PAUSED if shot_pause=1, regardless of the current state.
REQ-034 In RUN, tick_1hz SHALL decrement shot_count; a decrement from 1 to 0 SHALL enter EXPIRED and raise buzzer on the same edge.
REQ-035 RUN SHALL go to PAUSED while shot_pause=1, and PAUSED SHALL return to RUN when shot_pause=0; no decrement occurs in PAUSED.
REQ-036 In EXPIRED, shot_count SHALL hold 0 and SHALL NOT wrap; buzzer SHALL fall after BUZZ_TICKS further tick_1hz strobes.
REQ-037 EXPIRED SHALL be left only by shot_reset or clr.
REQ-038 shot_reset coincident with tick_1hz SHALL take priority: the preset is loaded and not decremented that cycle.
REQ-039 shot_reset during the alarm SHALL drop buzzer on the next cycle.
REQ-040 Score logic and shot clock SHALL be independent; clr_score SHALL NOT affect the shot clock.

Reset
REQ-041 On clr=1, all scores SHALL become 0, ovf 0, err 0, shot_count SHOT_LONG, FSM PAUSED and buzzer 0, all on the next edge.
REQ-042 clr SHALL override every other input in the same cycle, including mid-alarm and mid-operation.

Verification
REQ-043 clr; pts_valid, pts=3, team 1 -> scores team1 = 3 one cycle later, team0 = 0, err = 0.
REQ-044 Team 0 at 198, add 3 -> score 199, ovf[0]=1; then subtract 2 -> 197 with ovf[0] still 1.
REQ-045 Team 0 at 1, subtract 2 -> score stays 1, err high for exactly one cycle.
REQ-046 shot_reset with shot_short=1, then 14 ticks -> shot_count 14 down to 0, EXPIRED, buzzer high for 3 ticks, shot_count stays 0.
REQ-047 shot_reset and tick_1hz in the same cycle with shot_short=0 -> shot_count = 24; shot_pause high over 5 ticks -> count unchanged.
REQ-048 clr_score and pts_valid in the same cycle -> all scores 0, ovf 0, no err; the shot clock is unaffected.
